// File: rtl/zbc_iter_seq.sv
// zbc_iter_seq: multi-cycle sequencer for the Zbc carry-less multiplies (clmul, clmulh, clmulr).
// Accepts one operation through a valid/ready handshake, iterates a RADIX-bit-per-cycle
// XOR-shift accumulator over the (possibly reversed) B operand, and holds the result until taken.
//
// Ports:
//   clk, reset       clock, synchronous active-high reset
//   Flush            abort any in-flight operation; no response is produced
//   ReqValid/Ready   request handshake (ReqReady is high only in IDLE)
//   A, B, Funct3     operands and op select (Funct3[1:0]: 01 clmul, 11 clmulh, 10 clmulr)
//   RespValid/Ready  result handshake; ZBCResult is stable while RespValid is high
//   Busy             high while an operation is in BUSY or DONE
//
// Optional feature: define ZBC_EARLYOUT_EN to leave BUSY as soon as the remaining multiplier
// bits are all zero (variable latency, identical result).
module zbc_iter_seq #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned RADIX = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             Flush,
    input  logic             ReqValid,
    output logic             ReqReady,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [2:0]       Funct3,
    output logic             RespValid,
    input  logic             RespReady,
    output logic [WIDTH-1:0] ZBCResult,
    output logic             Busy
);

    localparam int unsigned Steps = WIDTH / RADIX;
    localparam int unsigned CntW  = $clog2(Steps) + 1;

    typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

    state_e            state_q, state_d;
    logic [WIDTH-1:0]  x_q, x_d;
    logic [WIDTH-1:0]  y_q, y_d;
    logic [WIDTH-1:0]  acc_q, acc_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic              hi_q, hi_d;      // result needs post-reversal (clmulh/clmulr)
    logic [WIDTH-1:0]  result_q, result_d;

    logic [WIDTH-1:0]  rev_a;
    logic [WIDTH-1:0]  acc_step;
    logic [WIDTH-1:0]  y_shift;
    logic              last_step;
    logic              early_out;
    logic              unused_funct3;

    assign unused_funct3 = Funct3[2];

    function automatic logic [WIDTH-1:0] rev(input logic [WIDTH-1:0] v);
        logic [WIDTH-1:0] r;
        for (int i = 0; i < int'(WIDTH); i++) begin
            r[i] = v[WIDTH-1-i];
        end
        return r;
    endfunction

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= StIdle;
            x_q      <= '0;
            y_q      <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            hi_q     <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            x_q      <= x_d;
            y_q      <= y_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            hi_q     <= hi_d;
            result_q <= result_d;
        end
    end

    // One radix step of the XOR-shift accumulator; bits shifted past WIDTH are dropped.
    always_comb begin
        acc_step = acc_q;
        for (int i = 0; i < int'(RADIX); i++) begin
            if (y_q[i]) begin
                acc_step = acc_step ^ (x_q << i);
            end
        end
    end

    assign rev_a     = rev(A);
    assign y_shift   = y_q >> RADIX;
    assign last_step = (cnt_q == CntW'(Steps - 1));

`ifdef ZBC_EARLYOUT_EN
    // Remaining partial products are all zero once Y runs out of set bits.
    assign early_out = (y_shift == '0);
`else
    assign early_out = 1'b0;
`endif

    // Next-state logic
    always_comb begin
        state_d  = state_q;
        x_d      = x_q;
        y_d      = y_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        hi_d     = hi_q;
        result_d = result_q;
        if (Flush) begin
            state_d = StIdle;
        end else begin
            case (state_q)
                StIdle: begin
                    if (ReqValid) begin
                        case (Funct3[1:0])
                            2'b10:   x_d = rev_a;
                            2'b11:   x_d = {rev_a[WIDTH-2:0], 1'b0};
                            default: x_d = A;   // 01 and the never-issued 00 both run clmul
                        endcase
                        y_d     = Funct3[1] ? rev(B) : B;
                        hi_d    = Funct3[1];
                        acc_d   = '0;
                        cnt_d   = '0;
                        state_d = StBusy;
                    end
                end
                StBusy: begin
                    acc_d = acc_step;
                    x_d   = x_q << RADIX;
                    y_d   = y_shift;
                    cnt_d = cnt_q + CntW'(1);
                    if (last_step || early_out) begin
                        result_d = hi_q ? rev(acc_step) : acc_step;
                        state_d  = StDone;
                    end
                end
                StDone: begin
                    if (RespReady) begin
                        state_d = StIdle;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    // Outputs
    always_comb begin
        ReqReady  = (state_q == StIdle);
        RespValid = (state_q == StDone);
        Busy      = (state_q == StBusy) || (state_q == StDone);
        ZBCResult = result_q;
    end

endmodule

// File: tb/tb_zbc_iter_seq.sv
module tb_zbc_iter_seq;

    localparam int unsigned W = 32;
    localparam int unsigned R = 4;
    localparam int unsigned Steps = W / R;

    logic         clk = 1'b0;
    logic         reset;
    logic         Flush;
    logic         ReqValid;
    logic         ReqReady;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic [2:0]   Funct3;
    logic         RespValid;
    logic         RespReady;
    logic [W-1:0] ZBCResult;
    logic         Busy;

    int checks = 0;
    int errors = 0;

    zbc_iter_seq #(.WIDTH(W), .RADIX(R)) dut (
        .clk       (clk),
        .reset     (reset),
        .Flush     (Flush),
        .ReqValid  (ReqValid),
        .ReqReady  (ReqReady),
        .A         (A),
        .B         (B),
        .Funct3    (Funct3),
        .RespValid (RespValid),
        .RespReady (RespReady),
        .ZBCResult (ZBCResult),
        .Busy      (Busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one edge; inputs are driven and outputs sampled 1 time unit after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [W-1:0] brev(input logic [W-1:0] v);
        logic [W-1:0] r;
        for (int i = 0; i < int'(W); i++) r[i] = v[W-1-i];
        return r;
    endfunction

    // Reference: full 2W-bit carry-less product, then select the requested window.
    function automatic logic [W-1:0] ref_clmul(input logic [W-1:0] a, input logic [W-1:0] b,
                                               input logic [1:0] f);
        logic [2*W-1:0] p = '0;
        for (int i = 0; i < int'(W); i++) begin
            if (b[i]) p = p ^ ({{W{1'b0}}, a} << i);
        end
        case (f)
            2'b11:   return p[2*W-1:W];
            2'b10:   return p[2*W-2:W-1];
            default: return p[W-1:0];
        endcase
    endfunction

    // Number of BUSY cycles expected for a given op.
    function automatic int exp_busy(input logic [W-1:0] b, input logic [1:0] f);
`ifdef ZBC_EARLYOUT_EN
        logic [2*W-1:0] y = {{W{1'b0}}, (f[1] ? brev(b) : b)};
        for (int k = 1; k <= int'(Steps); k++) begin
            if ((y >> (R * k)) == '0) return k;
        end
        return Steps;
`else
        if (f[1] && (b == b)) return Steps;
        return Steps;
`endif
    endfunction

    // Issue one op and wait (bounded) for its response; optional stall before taking it.
    task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [2:0] f, input int stall);
        int n;
        logic [W-1:0] exp;
        exp = ref_clmul(a, b, f[1:0]);
        chk({tag, ".req_ready"}, {63'd0, ReqReady}, 64'd1);
        A = a; B = b; Funct3 = f; ReqValid = 1'b1;
        step();
        ReqValid = 1'b0;
        A = $urandom; B = $urandom; Funct3 = 3'($urandom);
        n = 0;
        while (!RespValid && n < 40) begin
            step();
            n++;
        end
        chk({tag, ".latency"}, 64'(n), 64'(exp_busy(b, f[1:0])));
        chk({tag, ".result"}, {32'd0, ZBCResult}, {32'd0, exp});
        for (int s = 0; s < stall; s++) begin
            step();
            chk({tag, ".stall_valid"}, {63'd0, RespValid}, 64'd1);
            chk({tag, ".stall_result"}, {32'd0, ZBCResult}, {32'd0, exp});
            chk({tag, ".stall_req_ready"}, {63'd0, ReqReady}, 64'd0);
        end
        RespReady = 1'b1;
        step();
        RespReady = 1'b0;
        chk({tag, ".idle_valid"}, {63'd0, RespValid}, 64'd0);
        chk({tag, ".idle_busy"}, {63'd0, Busy}, 64'd0);
        chk({tag, ".hold_result"}, {32'd0, ZBCResult}, {32'd0, exp});
    endtask

    initial begin
        reset = 1'b1; Flush = 1'b0; ReqValid = 1'b0; RespReady = 1'b0;
        A = '0; B = '0; Funct3 = '0;
        step(); step();
        reset = 1'b0;
        chk("reset.req_ready", {63'd0, ReqReady}, 64'd1);
        chk("reset.resp_valid", {63'd0, RespValid}, 64'd0);
        chk("reset.busy", {63'd0, Busy}, 64'd0);
        chk("reset.result", {32'd0, ZBCResult}, 64'd0);

        run_op("clmul_3x3", 32'h3, 32'h3, 3'b001, 0);
        run_op("clmul_ff", 32'hFFFF_FFFF, 32'h2, 3'b001, 0);
        run_op("clmulh_msb", 32'h8000_0000, 32'h8000_0000, 3'b011, 0);
        run_op("clmulr_msb", 32'h8000_0000, 32'h8000_0000, 3'b010, 0);
        run_op("clmulh_ones", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 3'b011, 0);
        run_op("f3_00", 32'h1234_5678, 32'h0000_0F0F, 3'b100, 0);
        run_op("b_zero", 32'hDEAD_BEEF, 32'h0, 3'b001, 0);
        run_op("stall5", 32'hA5A5_0001, 32'h0000_0013, 3'b011, 5);

        // Directed spot checks of the reference against hand-derived values.
        chk("ref.clmulh_ones", {32'd0, ref_clmul(32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'b11)},
            64'h5555_5555);

        // Flush in the 3rd BUSY cycle.
        A = 32'h7; B = 32'h9; Funct3 = 3'b001; ReqValid = 1'b1;
        step();
        ReqValid = 1'b0;
        step(); step();
        Flush = 1'b1;
        step();
        Flush = 1'b0;
        chk("flush_busy.req_ready", {63'd0, ReqReady}, 64'd1);
        chk("flush_busy.busy", {63'd0, Busy}, 64'd0);
        for (int i = 0; i < 12; i++) begin
            step();
            chk("flush_busy.no_resp", {63'd0, RespValid}, 64'd0);
        end
        run_op("after_flush", 32'h3, 32'h3, 3'b001, 0);

        // Flush together with ReqValid in IDLE: not accepted.
        A = 32'h3; B = 32'h3; Funct3 = 3'b001; ReqValid = 1'b1; Flush = 1'b1;
        step();
        ReqValid = 1'b0; Flush = 1'b0;
        chk("flush_idle.req_ready", {63'd0, ReqReady}, 64'd1);
        chk("flush_idle.busy", {63'd0, Busy}, 64'd0);

        // Flush together with RespReady in DONE: result discarded, back to IDLE.
        A = 32'h5; B = 32'h5; Funct3 = 3'b001; ReqValid = 1'b1;
        step();
        ReqValid = 1'b0;
        for (int i = 0; i < 40 && !RespValid; i++) step();
        chk("flush_done.valid", {63'd0, RespValid}, 64'd1);
        chk("flush_done.result", {32'd0, ZBCResult}, 64'h11);
        Flush = 1'b1; RespReady = 1'b1;
        step();
        Flush = 1'b0; RespReady = 1'b0;
        chk("flush_done.resp_valid", {63'd0, RespValid}, 64'd0);
        chk("flush_done.req_ready", {63'd0, ReqReady}, 64'd1);

        // Reset during BUSY.
        A = 32'hFFFF_0000; B = 32'hFFFF_FFFF; Funct3 = 3'b011; ReqValid = 1'b1;
        step();
        ReqValid = 1'b0;
        step(); step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("reset_busy.req_ready", {63'd0, ReqReady}, 64'd1);
        chk("reset_busy.resp_valid", {63'd0, RespValid}, 64'd0);
        chk("reset_busy.busy", {63'd0, Busy}, 64'd0);
        chk("reset_busy.result", {32'd0, ZBCResult}, 64'd0);

        // Randomized ops against the reference model.
        for (int t = 0; t < 40; t++) begin
            logic [W-1:0] ra, rb;
            logic [2:0]   rf;
            ra = $urandom;
            rb = (t % 8 == 0) ? W'($urandom_range(0, 255)) : W'($urandom);
            rf = 3'($urandom);
            run_op("rand", ra, rb, rf, int'($urandom_range(0, 2)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
